booth_accumulator: RTL and testbench

Downstream consumer of the 4-bit Booth multiplier array: takes a stream of signed products over a valid/ready handshake and sums a fixed number of them (N_TERMS) into one signed dot-product result. Each addition saturates, and a sticky overflow flag is kept per result. The completed sum is presented on a registered valid/ready output port and held until it is taken. This stage turns the combinational multiplier into a usable multiply-accumulate datapath.

---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_sat_add.sv | 31 +++
 rtl/booth_accumulator.sv | 102 ++++++++++
 tb/tb_booth_accumulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiply-accumulate datapath.
// The default product width matches the multiplier array output.
package booth_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 12;

  // Saturation limits for a w-bit two's-complement accumulator.
  function automatic longint acc_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint acc_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational saturating adder: ACC_W accumulator plus sign-extended PROD_W product.
// The sum is formed one bit wider so that overflow shows up in the top two bits.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] wide;

  assign wide = {a[ACC_W-1], a} + {{(ACC_W + 1 - PROD_W){b[PROD_W-1]}}, b};

  // Top two bits disagree only when the true sum is outside the ACC_W range.
  assign sat = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    if (!sat)            sum = wide[ACC_W-1:0];
    else if (wide[ACC_W]) sum = ACC_MIN;
    else                 sum = ACC_MAX;
  end

endmodule

// File: rtl/booth_accumulator.sv
// Sums N_TERMS signed products into one saturated result with a sticky overflow flag,
// then holds the result on a registered valid/ready port until it is taken.
module booth_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [PROD_W-1:0] p_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf
);

  localparam int              CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic               ovf, ovf_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ACC_W-1:0]   sum;
  logic               sat;
  logic               accept;

  booth_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (p_data),
    .sum (sum),
    .sat (sat)
  );

  // Depends only on state, rst and clr so p_valid never loops back into p_ready.
  assign p_ready   = (state == ACCUM) && !rst && !clr;
  assign accept    = p_valid && p_ready;
  assign acc_valid = (state == HOLD);
  assign acc_data  = acc;
  assign acc_ovf   = ovf;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    cnt_n   = cnt;
    if (clr) begin
      state_n = ACCUM;
      acc_n   = '0;
      ovf_n   = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            acc_n = sum;
            ovf_n = ovf | sat;
            if (cnt == LAST) begin
              cnt_n   = '0;
              state_n = HOLD;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_n = ACCUM;
            acc_n   = '0;
            ovf_n   = 1'b0;
          end
        end
        default: state_n = ACCUM;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_booth_accumulator.sv
// Self-checking bench: a 12-bit and an 8-bit accumulator driven in lockstep,
// checked against fixed vectors and a plain-arithmetic saturation model.
`timescale 1ns/1ps
module tb_booth_accumulator;

  typedef struct packed {
    logic [3:0][7:0]    p;
    logic signed [11:0] e12;
    logic               o12;
    logic signed [7:0]  e8;
    logic               o8;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        p_valid;
  logic [7:0]  p_data;
  logic        acc_ready;
  logic        p_ready_a, p_ready_b;
  logic        acc_valid_a, acc_valid_b;
  logic [11:0] acc_data_a;
  logic [7:0]  acc_data_b;
  logic        acc_ovf_a, acc_ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  booth_accumulator u_dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .p_valid(p_valid), .p_ready(p_ready_a), .p_data(p_data),
    .acc_valid(acc_valid_a), .acc_ready(acc_ready),
    .acc_data(acc_data_a), .acc_ovf(acc_ovf_a)
  );

  booth_accumulator #(.ACC_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .p_valid(p_valid), .p_ready(p_ready_b), .p_data(p_data),
    .acc_valid(acc_valid_b), .acc_ready(acc_ready),
    .acc_data(acc_data_b), .acc_ovf(acc_ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int e12, input int o12, input int e8, input int o8);
    vec_t v;
    v.p[0] = 8'(a); v.p[1] = 8'(b); v.p[2] = 8'(c); v.p[3] = 8'(d);
    v.e12 = 12'(e12); v.o12 = o12[0];
    v.e8  = 8'(e8);   v.o8  = o8[0];
    return v;
  endfunction

  // Reference: running sum clamped to the w-bit signed range after every term.
  function automatic void model(input logic [3:0][7:0] p, input int w,
                                output int s, output int o);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s = 0;
    o = 0;
    for (int i = 0; i < 4; i++) begin
      s = s + int'($signed(p[i]));
      if (s > hi) begin s = hi; o = 1; end
      else if (s < lo) begin s = lo; o = 1; end
    end
  endfunction

  task automatic check_outputs(input string tag, input int valid, input int pr,
                               input int e12, input int o12, input int e8, input int o8);
    check({tag, " valid_a"}, int'(acc_valid_a), valid);
    check({tag, " valid_b"}, int'(acc_valid_b), valid);
    check({tag, " p_ready_a"}, int'(p_ready_a), pr);
    check({tag, " p_ready_b"}, int'(p_ready_b), pr);
    check({tag, " data_a"}, int'($signed(acc_data_a)), e12);
    check({tag, " ovf_a"}, int'(acc_ovf_a), o12);
    check({tag, " data_b"}, int'($signed(acc_data_b)), e8);
    check({tag, " ovf_b"}, int'(acc_ovf_b), o8);
  endtask

  // Feed four terms (optionally with idle gaps), hold the result for 'hold' extra
  // cycles with junk offered on p_data, then take it and confirm the return to ACCUM.
  task automatic run_result(input string tag, input logic [3:0][7:0] p, input int gaps,
                            input int hold, input int e12, input int o12,
                            input int e8, input int o8);
    for (int i = 0; i < 4; i++) begin
      if (gaps != 0 && $urandom_range(1) == 1) begin
        @(negedge clk);
        p_valid = 1'b0; p_data = 8'($urandom); acc_ready = $urandom_range(1) == 1;
      end
      @(negedge clk);
      p_valid = 1'b1; p_data = p[i]; acc_ready = 1'b0;
      #1;
      check({tag, " term p_ready"}, int'(p_ready_a & p_ready_b), 1);
      check({tag, " term valid"}, int'(acc_valid_a | acc_valid_b), 0);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      p_valid = 1'b1; p_data = 8'($urandom); acc_ready = (h == hold);
      #1;
      check_outputs({tag, " hold"}, 1, 0, e12, o12, e8, o8);
    end
    @(negedge clk);
    p_valid = 1'b0; acc_ready = 1'b0;
    #1;
    check_outputs({tag, " taken"}, 0, 1, 0, 0, 0, 0);
  endtask

  vec_t tbl[7];

  initial begin
    int s12, o12, s8, o8;
    logic [3:0][7:0] rp;

    tbl[0] = mk(6, -15, 64, -8,      47, 0,   47, 0);
    tbl[1] = mk(64, 64, 64, 64,     256, 0,  127, 1);
    tbl[2] = mk(-56, -56, -56, 64, -104, 0,  -64, 1);
    tbl[3] = mk(127, 127, 127, 127, 508, 0,  127, 1);
    tbl[4] = mk(-128, -128, -128, -128, -512, 0, -128, 1);
    tbl[5] = mk(0, 0, 0, 0,           0, 0,    0, 0);
    tbl[6] = mk(100, 100, -128, -128, -56, 0, -128, 1);

    rst = 1'b1; clr = 1'b0; p_valid = 1'b0; p_data = '0; acc_ready = 1'b0;
    #2;
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("post_reset", 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++)
      run_result($sformatf("vec%0d", i), tbl[i].p, 0, (i == 1) ? 5 : i % 3,
                 int'(tbl[i].e12), int'(tbl[i].o12), int'(tbl[i].e8), int'(tbl[i].o8));

    // clr with a concurrent product: 30 must be dropped along with 10 and 20.
    @(negedge clk); p_valid = 1'b1; p_data = 8'd10;
    @(negedge clk); p_valid = 1'b1; p_data = 8'd20;
    @(negedge clk); p_valid = 1'b1; p_data = 8'd30; clr = 1'b1;
    #1;
    check("clr p_ready", int'(p_ready_a | p_ready_b), 0);
    @(negedge clk); p_valid = 1'b0; clr = 1'b0;
    #1;
    check_outputs("after_clr", 0, 1, 0, 0, 0, 0);
    rp = tbl[0].p;
    rp[0] = 8'd1; rp[1] = 8'd2; rp[2] = 8'd3; rp[3] = 8'd4;
    run_result("clr_stream", rp, 0, 0, 10, 0, 10, 0);

    // clr while holding a result drops it.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); p_valid = 1'b1; p_data = 8'd64;
    end
    @(negedge clk); p_valid = 1'b0; clr = 1'b1;
    #1;
    check_outputs("clr_hold", 1, 0, 256, 0, 127, 1);
    @(negedge clk); clr = 1'b0;
    #1;
    check_outputs("clr_hold_after", 0, 1, 0, 0, 0, 0);

    // Asynchronous reset between edges while in HOLD.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); p_valid = 1'b1; p_data = 8'd64;
    end
    @(negedge clk); p_valid = 1'b0; acc_ready = 1'b0;
    #1;
    check_outputs("pre_rst_hold", 1, 0, 256, 0, 127, 1);
    #1 rst = 1'b1;
    #1;
    check_outputs("rst_in_hold", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check_outputs("rst_release", 0, 1, 0, 0, 0, 0);
    run_result("after_rst", tbl[2].p, 0, 1, -104, 0, -64, 1);

    // Random streams with idle gaps and random hold lengths.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) rp[i] = 8'($urandom);
      model(rp, 12, s12, o12);
      model(rp, 8, s8, o8);
      run_result($sformatf("rand%0d", r), rp, 1, $urandom_range(3), s12, o12, s8, o8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
